// File: rtl/f1_race_sequencer.sv
// F1 reaction-timer sequencer: start lights, random hold, reaction timing.
// All outputs registered; prescalers restart on entry to the states that use them.
module f1_race_sequencer #(
  parameter int TICK_DIV      = 25_000_000,
  parameter int MS_DIV        = 50_000,
  parameter int N_LIGHTS      = 5,
  parameter int DELAY_BASE_MS = 200,
  parameter int DELAY_STEP_MS = 8,
  parameter int RT_MAX        = 9999,
  parameter int RT_W          = 14
) (
  input  logic            sysclk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            react,
  output logic [9:0]      ledr,
  output logic            busy,
  output logic            jump_start,
  output logic [RT_W-1:0] result,
  output logic            result_valid
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int MW = $clog2(MS_DIV);
  localparam int LW = 4;

  typedef enum logic [2:0] {
    IDLE, LIGHTS, HOLD, TIMING, DONE, FAULT
  } state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   tick_cnt;
  logic [MW-1:0]   ms_cnt;
  logic [6:0]      lfsr;
  logic [LW-1:0]   lit, lit_nx;
  logic [15:0]     delay, delay_nx;
  logic [RT_W-1:0] rt, rt_nx;
  logic [RT_W-1:0] result_nx;
  logic [9:0]      ledr_nx;
  logic            valid_nx;
  logic            tick, ms, enter;

  function automatic logic [9:0] bar(input logic [LW-1:0] n);
    logic [10:0] one_hot;
    one_hot = 11'd1 << n;
    return 10'(one_hot - 11'd1);
  endfunction

  assign tick  = tick_cnt == TW'(TICK_DIV - 1);
  assign ms    = ms_cnt == MW'(MS_DIV - 1);
  assign enter = state_nx != state;

  always_comb begin
    state_nx  = state;
    lit_nx    = lit;
    delay_nx  = delay;
    rt_nx     = rt;
    ledr_nx   = ledr;
    result_nx = result;
    valid_nx  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx  = LIGHTS;
          lit_nx    = LW'(1);
          ledr_nx   = bar(LW'(1));
          result_nx = '0;
        end
      end
      LIGHTS: begin
        if (react) begin
          state_nx  = FAULT;
          ledr_nx   = 10'h3FF;
          result_nx = '0;
        end else if (tick) begin
          if (lit < LW'(N_LIGHTS)) begin
            lit_nx  = lit + LW'(1);
            ledr_nx = bar(lit + LW'(1));
          end else begin
            state_nx = HOLD;
            delay_nx = 16'(DELAY_BASE_MS)
                     + 16'(DELAY_STEP_MS) * {9'd0, lfsr};
            ledr_nx  = bar(LW'(N_LIGHTS));
          end
        end
      end
      HOLD: begin
        if (react) begin
          state_nx  = FAULT;
          ledr_nx   = 10'h3FF;
          result_nx = '0;
        end else if (ms) begin
          if (delay <= 16'd1) begin
            state_nx = TIMING;
            ledr_nx  = '0;
            rt_nx    = '0;
          end else begin
            delay_nx = delay - 16'd1;
          end
        end
      end
      TIMING: begin
        if (react) begin
          state_nx  = DONE;
          result_nx = rt;
          valid_nx  = 1'b1;
        end else if (ms) begin
          // Reaching the ceiling ends the race as if the driver reacted.
          if (rt >= RT_W'(RT_MAX - 1)) begin
            state_nx  = DONE;
            result_nx = RT_W'(RT_MAX);
            valid_nx  = 1'b1;
          end else begin
            rt_nx = rt + RT_W'(1);
          end
        end
      end
      FAULT: begin
        if (start) begin
          state_nx  = LIGHTS;
          lit_nx    = LW'(1);
          ledr_nx   = bar(LW'(1));
          result_nx = '0;
        end else if (tick) begin
          ledr_nx = ~ledr;
        end
      end
      default: begin
        state_nx = IDLE;
        ledr_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      ms_cnt       <= '0;
      lfsr         <= 7'h01;
      lit          <= '0;
      delay        <= '0;
      rt           <= '0;
      ledr         <= '0;
      busy         <= 1'b0;
      jump_start   <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_nx;
      lfsr         <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      lit          <= lit_nx;
      delay        <= delay_nx;
      rt           <= rt_nx;
      ledr         <= ledr_nx;
      result       <= result_nx;
      result_valid <= valid_nx;
      busy         <= state_nx == LIGHTS || state_nx == HOLD
                   || state_nx == TIMING;
      jump_start   <= state_nx == FAULT;
      if ((enter && (state_nx == LIGHTS || state_nx == FAULT)) || tick)
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + TW'(1);
      if ((enter && (state_nx == HOLD || state_nx == TIMING)) || ms)
        ms_cnt <= '0;
      else
        ms_cnt <= ms_cnt + MW'(1);
    end
  end

endmodule

// File: tb/tb_f1_race_sequencer.sv
// Bench for f1_race_sequencer: phase/elapsed-time model checked every cycle,
// plus directed races with literal expectations.
module tb_f1_race_sequencer;

  localparam int TICK_DIV = 4;
  localparam int MS_DIV   = 2;
  localparam int NL       = 5;
  localparam int D_BASE   = 2;
  localparam int D_STEP   = 1;
  localparam int RT_MAX   = 20;
  localparam int RT_W     = 14;

  localparam int P_IDLE = 0, P_LIGHTS = 1, P_HOLD = 2;
  localparam int P_TIMING = 3, P_DONE = 4, P_FAULT = 5;

  logic            sysclk = 1'b0;
  logic            rst_n  = 1'b0;
  logic            start  = 1'b0;
  logic            react  = 1'b0;
  logic [9:0]      ledr;
  logic            busy;
  logic            jump_start;
  logic [RT_W-1:0] result;
  logic            result_valid;

  int n_checks = 0;
  int n_errors = 0;

  f1_race_sequencer #(
    .TICK_DIV(TICK_DIV), .MS_DIV(MS_DIV), .N_LIGHTS(NL),
    .DELAY_BASE_MS(D_BASE), .DELAY_STEP_MS(D_STEP),
    .RT_MAX(RT_MAX), .RT_W(RT_W)
  ) dut (
    .sysclk(sysclk), .rst_n(rst_n), .start(start), .react(react),
    .ledr(ledr), .busy(busy), .jump_start(jump_start),
    .result(result), .result_valid(result_valid)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h",
               name, $time, act, exp);
    end
  endtask

  // Model: current phase, edges since entering it, lfsr, result.
  int         m_phase = P_IDLE;
  int         m_el    = 0;
  int         m_hold  = 0;
  int         m_result = 0;
  int         m_valid = 0;
  logic [6:0] m_lfsr  = 7'h01;

  task automatic model_step(input logic s, input logic r, input logic rn);
    logic [6:0] lp;
    int ne, nxt;
    if (!rn) begin
      m_phase = P_IDLE; m_el = 0; m_result = 0;
      m_valid = 0; m_lfsr = 7'h01;
      return;
    end
    lp = m_lfsr;
    m_lfsr = {lp[5:0], lp[6] ^ lp[5]};
    m_valid = 0;
    ne = m_el + 1;
    nxt = m_phase;
    case (m_phase)
      P_IDLE, P_DONE, P_FAULT:
        if (s) begin nxt = P_LIGHTS; m_result = 0; end
      P_LIGHTS:
        if (r) nxt = P_FAULT;
        else if (ne == TICK_DIV * NL) begin
          nxt = P_HOLD;
          m_hold = (D_BASE + D_STEP * int'(lp)) * MS_DIV;
        end
      P_HOLD:
        if (r) nxt = P_FAULT;
        else if (ne == m_hold) nxt = P_TIMING;
      P_TIMING:
        if (r) begin
          nxt = P_DONE; m_result = m_el / MS_DIV; m_valid = 1;
        end else if (ne == RT_MAX * MS_DIV) begin
          nxt = P_DONE; m_result = RT_MAX; m_valid = 1;
        end
      default: nxt = P_IDLE;
    endcase
    if (nxt != m_phase) m_el = 0;
    else m_el = ne;
    m_phase = nxt;
  endtask

  function automatic int exp_ledr();
    case (m_phase)
      P_LIGHTS: return (1 << (1 + m_el / TICK_DIV)) - 1;
      P_HOLD:   return (1 << NL) - 1;
      P_FAULT:  return ((m_el / TICK_DIV) % 2 == 0) ? 'h3FF : 0;
      default:  return 0;
    endcase
  endfunction

  always @(posedge sysclk) begin
    model_step(start, react, rst_n);
    #1;
    chk("ledr", int'(ledr), exp_ledr());
    chk("busy", int'(busy), int'(m_phase == P_LIGHTS
        || m_phase == P_HOLD || m_phase == P_TIMING));
    chk("jump_start", int'(jump_start), int'(m_phase == P_FAULT));
    chk("result", int'(result), m_result);
    chk("result_valid", int'(result_valid), m_valid);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_blank();
    int n;
    n = 0;
    while (ledr != 10'h000 && n < 600) begin
      cyc(1);
      n++;
    end
    chk("blank_timeout", int'(n < 600), 1);
  endtask

  initial begin
    int hl;
    cyc(3);
    chk("rst_ledr", int'(ledr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_result", int'(result), 0);
    rst_n = 1'b1;
    cyc(2);

    // Light sequence, 4 cycles per step, then hold and blank.
    pulse_start();
    chk("led1", int'(ledr), 'h001);
    cyc(4); chk("led2", int'(ledr), 'h003);
    cyc(4); chk("led3", int'(ledr), 'h007);
    cyc(4); chk("led4", int'(ledr), 'h00F);
    cyc(4); chk("led5", int'(ledr), 'h01F);
    wait_blank();
    chk("blank_busy", int'(busy), 1);
    cyc(12);
    react = 1'b1;
    cyc(1);
    react = 1'b0;
    chk("rt6_result", int'(result), 6);
    chk("rt6_valid", int'(result_valid), 1);
    chk("rt6_busy", int'(busy), 0);
    cyc(1);
    chk("rt6_valid_drop", int'(result_valid), 0);
    cyc(3);

    // Reset in the middle of timing.
    pulse_start();
    wait_blank();
    cyc(5);
    rst_n = 1'b0;
    cyc(3);
    chk("mid_rst_ledr", int'(ledr), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_valid", int'(result_valid), 0);
    rst_n = 1'b1;
    cyc(2);

    // Jump start after the second light.
    pulse_start();
    cyc(4);
    chk("js_led2", int'(ledr), 'h003);
    react = 1'b1;
    cyc(1);
    react = 1'b0;
    chk("js_flag", int'(jump_start), 1);
    chk("js_on", int'(ledr), 'h3FF);
    cyc(4); chk("js_off", int'(ledr), 0);
    cyc(4); chk("js_on2", int'(ledr), 'h3FF);
    pulse_start();
    chk("js_clear", int'(jump_start), 0);
    chk("js_restart", int'(ledr), 'h001);

    // No reaction: saturate at RT_MAX.
    wait_blank();
    cyc(39);
    chk("sat_pending", int'(result_valid), 0);
    cyc(1);
    chk("sat_result", int'(result), RT_MAX);
    chk("sat_valid", int'(result_valid), 1);
    cyc(1);
    chk("sat_valid_drop", int'(result_valid), 0);
    chk("sat_hold", int'(result), RT_MAX);

    // start and react together in DONE: start wins.
    start = 1'b1; react = 1'b1;
    cyc(1);
    start = 1'b0; react = 1'b0;
    chk("sr_ledr", int'(ledr), 'h001);
    chk("sr_jump", int'(jump_start), 0);
    chk("sr_result", int'(result), 0);

    // Stray starts in LIGHTS/HOLD, then react on the expiring HOLD cycle.
    cyc(5);
    pulse_start();
    hl = 0;
    while (m_phase != P_HOLD && hl < 100) begin cyc(1); hl++; end
    chk("hold_timeout", int'(hl < 100), 1);
    hl = m_hold;
    pulse_start();
    cyc(hl - 2);
    chk("exp_still_hold", int'(ledr), 'h01F);
    react = 1'b1;
    cyc(1);
    react = 1'b0;
    chk("exp_fault", int'(jump_start), 1);
    chk("exp_novalid", int'(result_valid), 0);
    chk("exp_ledr", int'(ledr), 'h3FF);
    cyc(6);
    pulse_start();
    cyc(8);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
